// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared ALU selection codes, FSM state encoding and flag-bit order for seq_alu, write-back and hazard logic
package seq_alu_pkg;
  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_OR   = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_SLL  = 4'h5;
  localparam logic [3:0] ALU_SRL  = 4'h6;
  localparam logic [3:0] ALU_SRA  = 4'h7;
  localparam logic [3:0] ALU_SLT  = 4'h8;
  localparam logic [3:0] ALU_SLTU = 4'h9;
  localparam logic [3:0] ALU_PASS = 4'hA;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;
  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_OVF   = 2;
  localparam int FLAG_NEG   = 3;
  localparam int FLAG_W     = 4;
  function automatic logic is_shift(input logic [3:0] sel);
    return sel == ALU_SLL || sel == ALU_SRL || sel == ALU_SRA;
  endfunction
endpackage

// File: rtl/seq_alu_if.sv
// seq_alu_if: request/result handshake bundle of seq_alu
//   master drives in_valid, alu_sel, op_a, op_b, out_ready
//   slave (seq_alu) drives in_ready, out_valid, result, zero, carry, overflow, negative, busy
interface seq_alu_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_sel;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;
  logic             overflow;
  logic             negative;
  logic             busy;
  modport master(output in_valid, alu_sel, op_a, op_b, out_ready,
                 input in_ready, out_valid, result, zero, carry, overflow, negative, busy);
  modport slave(input in_valid, alu_sel, op_a, op_b, out_ready,
                output in_ready, out_valid, result, zero, carry, overflow, negative, busy);
endinterface

// File: rtl/seq_alu_shifter.sv
// seq_alu_shifter: shift engine of seq_alu
//   clk, rst_n  clock, async active-low reset
//   start       load data/shamt/sel (iterative build)
//   sel, data, shamt  shift kind, operand, amount
//   done        final step this cycle; result holds the shifted value
//   SEQ_ALU_FAST_SHIFT_EN: combinational barrel shifter, done = start
module seq_alu_shifter
  import seq_alu_pkg::*;
#(parameter int WIDTH = 32, localparam int SW = $clog2(WIDTH))
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       sel,
  input  logic [WIDTH-1:0] data,
  input  logic [SW-1:0]    shamt,
  output logic             done,
  output logic [WIDTH-1:0] result
);
`ifdef SEQ_ALU_FAST_SHIFT_EN
  logic unused;
  assign unused = clk ^ rst_n;
  assign done = start;
  assign result = sel == ALU_SLL ? data << shamt :
                  sel == ALU_SRA ? $unsigned($signed(data) >>> shamt) : data >> shamt;
`else
  logic [WIDTH-1:0] work;
  logic [SW-1:0]    cnt;
  logic [3:0]       kind;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      work <= '0;
      cnt  <= '0;
      kind <= '0;
    end else if (start) begin
      work <= data;
      cnt  <= shamt;
      kind <= sel;
    end else if (cnt != '0) begin
      work <= result;
      cnt  <= cnt - 1'b1;
    end
  // result is the one-bit-shifted working value, so the last step can be captured by the owner on the same edge
  assign result = kind == ALU_SLL ? {work[WIDTH-2:0], 1'b0} : {kind == ALU_SRA && work[WIDTH-1], work[WIDTH-1:1]};
  assign done = cnt == SW'(1);
`endif
endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU executing ALU_* codes behind a valid/ready handshake
//   clk, rst_n  clock, async active-low reset
//   bus         seq_alu_if slave: request (in_valid/in_ready, alu_sel, op_a, op_b),
//               response (out_valid/out_ready, result, zero, carry, overflow, negative), busy
//   SEQ_ALU_FAST_SHIFT_EN: single-cycle shifts, SHIFT state removed
module seq_alu
  import seq_alu_pkg::*;
#(parameter int WIDTH = 32, localparam int SW = $clog2(WIDTH))
(
  input  logic   clk,
  input  logic   rst_n,
  seq_alu_if.slave bus
);
  state_e             state, state_nx;
  logic [WIDTH-1:0]   result, res_nx, calc, b_eff, sh_res;
  logic [FLAG_W-1:0]  flags, flg_nx;
  logic [WIDTH:0]     sum;
  logic               sub, arith, ovf, start, load, sh_done;
  logic [SW-1:0]      shamt;
  assign shamt = bus.op_b[SW-1:0];
  seq_alu_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clk(clk), .rst_n(rst_n), .start(start), .sel(bus.alu_sel),
    .data(bus.op_a), .shamt(shamt), .done(sh_done), .result(sh_res)
  );
  // SUB reuses the adder as a + ~b + 1 so carry-out means "no borrow"
  assign sub   = bus.alu_sel == ALU_SUB;
  assign arith = sub || bus.alu_sel == ALU_ADD;
  assign b_eff = sub ? ~bus.op_b : bus.op_b;
  assign sum   = {1'b0, bus.op_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
  assign ovf   = bus.op_a[WIDTH-1] == b_eff[WIDTH-1] && sum[WIDTH-1] != bus.op_a[WIDTH-1];
  always_comb begin
    calc = '0;
    case (bus.alu_sel)
      ALU_ADD, ALU_SUB: calc = sum[WIDTH-1:0];
      ALU_AND:  calc = bus.op_a & bus.op_b;
      ALU_OR:   calc = bus.op_a | bus.op_b;
      ALU_XOR:  calc = bus.op_a ^ bus.op_b;
      ALU_SLT:  calc = WIDTH'($signed(bus.op_a) < $signed(bus.op_b));
      ALU_SLTU: calc = WIDTH'(bus.op_a < bus.op_b);
      ALU_PASS: calc = bus.op_b;
`ifdef SEQ_ALU_FAST_SHIFT_EN
      ALU_SLL, ALU_SRL, ALU_SRA: calc = sh_res;
`else
      ALU_SLL, ALU_SRL, ALU_SRA: calc = bus.op_a;
`endif
      default:  calc = '0;
    endcase
  end
  always_comb begin
    state_nx = state;
    start    = 1'b0;
    load     = 1'b0;
    res_nx   = calc;
    case (state)
      S_IDLE: if (bus.in_valid) begin
`ifdef SEQ_ALU_FAST_SHIFT_EN
        load     = 1'b1;
        state_nx = S_DONE;
`else
        start    = is_shift(bus.alu_sel) && shamt != '0;
        load     = !start;
        state_nx = start ? S_SHIFT : S_DONE;
`endif
      end
`ifndef SEQ_ALU_FAST_SHIFT_EN
      S_SHIFT: if (sh_done) begin
        load     = 1'b1;
        res_nx   = sh_res;
        state_nx = S_DONE;
      end
`endif
      default: state_nx = bus.out_ready ? S_IDLE : state;
    endcase
    flg_nx[FLAG_ZERO]  = res_nx == '0;
    flg_nx[FLAG_NEG]   = res_nx[WIDTH-1];
    flg_nx[FLAG_CARRY] = state == S_IDLE && arith && sum[WIDTH];
    flg_nx[FLAG_OVF]   = state == S_IDLE && arith && ovf;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= S_IDLE;
      result <= '0;
      flags  <= '0;
    end else begin
      state <= state_nx;
      if (load) begin
        result <= res_nx;
        flags  <= flg_nx;
      end
    end
  assign bus.in_ready  = state == S_IDLE;
  assign bus.out_valid = state == S_DONE;
  assign bus.busy      = state != S_IDLE;
  assign bus.result    = result;
  assign bus.zero      = flags[FLAG_ZERO];
  assign bus.carry     = flags[FLAG_CARRY];
  assign bus.overflow  = flags[FLAG_OVF];
  assign bus.negative  = flags[FLAG_NEG];
endmodule
